// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, decoder word, and redirect controls from EX.
// The master side is the fetch unit; the slave side is control/ROM.
interface fetch_unit_if #(
  parameter int ADDR_W = 12
);
  logic              rom_rd;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic [15:0]       ROM_data;
  logic              jump_sel;
  logic [ADDR_W-1:0] jump_target;
  logic              beq_sel;
  logic              alu_eq;
  logic [5:0]        branch_off;
  logic              silence;
  logic [ADDR_W-1:0] ret_addr;
  logic              redirect;

  modport master (
    input  rom_rd, rom_q, jump_sel, jump_target, beq_sel, alu_eq,
           branch_off, silence,
    output rom_addr, ROM_data, ret_addr, redirect
  );

  modport slave (
    output rom_rd, rom_q, jump_sel, jump_target, beq_sel, alu_eq,
           branch_off, silence,
    input  rom_addr, ROM_data, ret_addr, redirect
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues ROM addresses, presents the
// fetched word to decode, and applies jump/branch redirects from EX.
// The word fetched in the redirect cycle is squashed here through flush_r;
// the older wrong-path word is squashed by control through silence.
module fetch_unit #(
  parameter int                ADDR_W  = 12,
  parameter logic [ADDR_W-1:0] BOOT_PC = {ADDR_W{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Sign-extend the 6-bit beq word offset to the PC width.
  function automatic logic [ADDR_W-1:0] sext_off(input logic [5:0] off);
    sext_off = {{(ADDR_W-6){off[5]}}, off};
  endfunction

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_id_r;
  logic [ADDR_W-1:0] pc_ex_r;
  logic              v_id_r;
  logic              flush_r;

  logic [ADDR_W-1:0] pc_nxt_s;
  logic [ADDR_W-1:0] pc_id_nxt_s;
  logic              v_id_nxt_s;
  logic              flush_nxt_s;
  logic              branch_take_s;
  logic              redirect_s;
  logic [ADDR_W-1:0] branch_tgt_s;
  logic [ADDR_W-1:0] target_s;

  // Resolve whether EX redirects and where to; a jump beats a taken beq.
  always_comb begin
    branch_take_s = ~bus.beq_sel & bus.alu_eq;
    redirect_s    = bus.jump_sel | branch_take_s;
    branch_tgt_s  = pc_ex_r + PC_ONE + sext_off(bus.branch_off);
    if (bus.jump_sel) begin
      target_s = bus.jump_target;
    end else begin
      target_s = branch_tgt_s;
    end
  end

  // Next-state for PC and the decode-side flags; a redirect overrides a stall.
  always_comb begin
    pc_nxt_s    = pc_r;
    pc_id_nxt_s = pc_id_r;
    v_id_nxt_s  = 1'b0;
    flush_nxt_s = 1'b0;
    if (redirect_s) begin
      pc_nxt_s    = target_s;
      pc_id_nxt_s = pc_r;
      v_id_nxt_s  = 1'b1;
      flush_nxt_s = 1'b1;
    end else if (bus.rom_rd) begin
      pc_nxt_s    = pc_r + PC_ONE;
      pc_id_nxt_s = pc_r;
      v_id_nxt_s  = 1'b1;
      flush_nxt_s = 1'b0;
    end else begin
      pc_nxt_s    = pc_r;
      pc_id_nxt_s = pc_id_r;
      v_id_nxt_s  = 1'b0;
      flush_nxt_s = 1'b0;
    end
  end

  // Pipeline registers; reset kills every in-flight word and returns to boot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r    <= BOOT_PC;
      pc_id_r <= BOOT_PC;
      pc_ex_r <= BOOT_PC;
      v_id_r  <= 1'b0;
      flush_r <= 1'b0;
    end else begin
      pc_r    <= pc_nxt_s;
      pc_id_r <= pc_id_nxt_s;
      pc_ex_r <= pc_id_r;
      v_id_r  <= v_id_nxt_s;
      flush_r <= flush_nxt_s;
    end
  end

  assign bus.rom_addr = pc_r;
  assign bus.ret_addr = pc_ex_r + PC_ONE;
  assign bus.redirect = redirect_s;
  assign bus.ROM_data = (v_id_r & ~flush_r & ~bus.silence) ? bus.rom_q : 16'h0000;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the ROM model returns 0x1000+addr.
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fetch_unit_if #(.ADDR_W(12)) bus ();

  fetch_unit #(.ADDR_W(12), .BOOT_PC(12'h000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for the address of this cycle appears next cycle.
  always @(posedge clk) bus.rom_q <= 16'h1000 + {4'h0, bus.rom_addr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Release reset and follow the sequential fetch from BOOT_PC up to pc=last.
  task automatic seq_from_boot(input int last);
    rst = 1'b1;
    chk_d("boot_data0", bus.ROM_data, 16'h0000);
    chk_a("boot_addr0", bus.rom_addr, 12'h000);
    step();
    chk_a("boot_addr1", bus.rom_addr, 12'h001);
    chk_d("boot_data1", bus.ROM_data, 16'h1000);
    for (int n = 2; n <= last; n++) begin
      step();
      chk_a("seq_addr", bus.rom_addr, n[11:0]);
      chk_d("seq_data", bus.ROM_data, 16'h0FFF + n[15:0]);
      chk_a("seq_ret", bus.ret_addr, n[11:0] - 12'd1);
    end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst             = 1'b0;
    bus.rom_rd      = 1'b1;
    bus.jump_sel    = 1'b0;
    bus.jump_target = 12'h000;
    bus.beq_sel     = 1'b1;
    bus.alu_eq      = 1'b0;
    bus.branch_off  = 6'h00;
    bus.silence     = 1'b0;

    // Reset state
    step();
    step();
    chk_a("rst_addr", bus.rom_addr, 12'h000);
    chk_d("rst_data", bus.ROM_data, 16'h0000);
    chk_a("rst_ret", bus.ret_addr, 12'h001);
    chk_b("rst_redir", bus.redirect, 1'b0);

    // Sequential fetch until pc_ex = 0x005
    seq_from_boot(7);

    // Jump to 0x040 from pc_ex = 0x005
    bus.jump_sel    = 1'b1;
    bus.jump_target = 12'h040;
    #1;
    chk_b("jmp_redir", bus.redirect, 1'b1);
    step();
    bus.jump_sel = 1'b0;
    chk_a("jmp_addr", bus.rom_addr, 12'h040);
    chk_d("jmp_squash", bus.ROM_data, 16'h0000);
    step();
    chk_d("jmp_tgt_data", bus.ROM_data, 16'h1040);
    chk_a("jmp_addr_nxt", bus.rom_addr, 12'h041);
    step();
    chk_d("jmp_data2", bus.ROM_data, 16'h1041);
    chk_a("jmp_ret", bus.ret_addr, 12'h041);

    // Jump to 0x010 to set up pc_ex = 0x010 two cycles later
    bus.jump_sel    = 1'b1;
    bus.jump_target = 12'h010;
    step();
    bus.jump_sel = 1'b0;
    step();
    step();
    chk_a("beq_setup_ret", bus.ret_addr, 12'h011);
    chk_a("beq_setup_addr", bus.rom_addr, 12'h012);

    // Taken beq: 0x010 + 1 - 4 = 0x00D
    bus.beq_sel    = 1'b0;
    bus.alu_eq     = 1'b1;
    bus.branch_off = 6'h3C;
    #1;
    chk_b("beq_redir", bus.redirect, 1'b1);
    step();
    bus.beq_sel = 1'b1;
    chk_a("beq_addr", bus.rom_addr, 12'h00D);
    chk_d("beq_squash", bus.ROM_data, 16'h0000);
    step();
    chk_d("beq_tgt_data", bus.ROM_data, 16'h100D);
    step();
    chk_a("beq_after_addr", bus.rom_addr, 12'h00F);

    // Not-taken beq: no redirect, sequential address
    bus.beq_sel    = 1'b0;
    bus.alu_eq     = 1'b0;
    bus.branch_off = 6'h3C;
    #1;
    chk_b("beq_nt_redir", bus.redirect, 1'b0);
    step();
    bus.beq_sel = 1'b1;
    chk_a("beq_nt_addr", bus.rom_addr, 12'h010);
    chk_d("beq_nt_data", bus.ROM_data, 16'h100F);

    // Wrap at the top of the address space
    bus.jump_sel    = 1'b1;
    bus.jump_target = 12'hFFE;
    step();
    bus.jump_sel = 1'b0;
    step();
    chk_a("wrap_fff", bus.rom_addr, 12'hFFF);
    chk_d("wrap_dffe", bus.ROM_data, 16'h1FFE);
    step();
    chk_a("wrap_000", bus.rom_addr, 12'h000);
    chk_d("wrap_dfff", bus.ROM_data, 16'h1FFF);
    step();
    chk_a("wrap_ret", bus.ret_addr, 12'h000);
    step();
    step();
    step();
    chk_a("bneg_setup", bus.ret_addr, 12'h003);

    // Taken beq with negative wrap: 0x002 + 1 - 8 = 0xFFB
    bus.beq_sel    = 1'b0;
    bus.alu_eq     = 1'b1;
    bus.branch_off = 6'h38;
    step();
    bus.beq_sel = 1'b1;
    chk_a("bneg_addr", bus.rom_addr, 12'hFFB);

    // Jump and taken beq together while flush is set: jump wins
    bus.jump_sel    = 1'b1;
    bus.jump_target = 12'h100;
    bus.beq_sel     = 1'b0;
    bus.alu_eq      = 1'b1;
    bus.branch_off  = 6'h01;
    step();
    bus.jump_sel = 1'b0;
    bus.beq_sel  = 1'b1;
    bus.alu_eq   = 1'b0;
    chk_a("prio_addr", bus.rom_addr, 12'h100);
    chk_d("prio_squash", bus.ROM_data, 16'h0000);
    step();
    chk_d("prio_data", bus.ROM_data, 16'h1100);

    // Back-to-back redirects: second target wins
    bus.jump_sel    = 1'b1;
    bus.jump_target = 12'h200;
    step();
    chk_a("b2b_first", bus.rom_addr, 12'h200);
    bus.jump_target = 12'h300;
    step();
    bus.jump_sel = 1'b0;
    chk_a("b2b_second", bus.rom_addr, 12'h300);
    chk_d("b2b_squash", bus.ROM_data, 16'h0000);
    step();
    chk_d("b2b_data", bus.ROM_data, 16'h1300);
    step();
    chk_a("b2b_addr", bus.rom_addr, 12'h302);

    // Three-cycle stall: address holds, three zero words
    bus.rom_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_a("stall_addr", bus.rom_addr, 12'h302);
      chk_d("stall_data", bus.ROM_data, 16'h0000);
    end
    bus.rom_rd = 1'b1;
    step();
    chk_a("resume_addr", bus.rom_addr, 12'h303);
    chk_d("resume_data", bus.ROM_data, 16'h1302);

    // Silence masks the word combinationally
    bus.silence = 1'b1;
    #1;
    chk_d("silence_on", bus.ROM_data, 16'h0000);
    bus.silence = 1'b0;
    #1;
    chk_d("silence_off", bus.ROM_data, 16'h1302);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk_a("arst_addr", bus.rom_addr, 12'h000);
    chk_d("arst_data", bus.ROM_data, 16'h0000);
    chk_a("arst_ret", bus.ret_addr, 12'h001);
    step();
    chk_a("arst_hold", bus.rom_addr, 12'h000);
    seq_from_boot(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 16-bit core. It owns the program counter, issues addresses to the synchronous instruction ROM and presents the fetched word on `ROM_data` to the control decoder. It applies the jump and branch redirects that the decoder requests through its JUMP/BEQ selects, squashes the wrong-path word, and supplies the return address used by `jal`.

## Interface
- `ADDR_W`, 12: PC / ROM address width; matches the 12-bit jump address field.
- `BOOT_PC`, 0: PC value loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-low (`rst==0` resets).
- `rom_rd`  in  1  fetch enable from control. 0 = stall PC and issue no fetch.
- `rom_addr`  out  ADDR_W  address to the instruction ROM. The ROM returns data one cycle later on `rom_q`.
- `rom_q`  in  16  ROM read data.
- `ROM_data`  out  16  instruction to control. `16'h0000` is the null instruction (NOP).
- `jump_sel`  in  1  JUMP_MUX from control: 1 = jump during the current EX cycle.
- `jump_target`  in  ADDR_W  ALU result during EX; the jump destination.
- `beq_sel`  in  1  BEQ_MUX from control. Active-low: 0 = EX holds a beq.
- `alu_eq`  in  1  ALU compare result for beq (1 = operands equal).
- `branch_off`  in  6  signed word offset of the beq in EX.
- `silence`  in  1  SILENCE_MUX from control: 1 forces `ROM_data` to 0.
- `ret_addr`  out  ADDR_W  `pc_ex+1`, the link value for jal (SAVE_PC path).
- `redirect`  out  1  1 during any cycle in which a redirect is being taken.

## Operation
- Registers:
  - `pc`, which drives `rom_addr`.
  - `pc_id`, the address of the word on `ROM_data`.
  - `pc_ex`, the address of the instruction in EX.
  - `v_id`, set when the word on `rom_q` came from an issued fetch.
  - `flush`, a 1-bit squash flag.
- `redirect = jump_sel | (~beq_sel & alu_eq)`. When both are asserted, the jump has priority.
- Target selection:
  - Jump target: `jump_target`.
  - Branch target: `pc_ex + 1 + sext(branch_off)`.
  - All PC arithmetic is modulo 2^ADDR_W and wraps silently (0xFFF+1 → 0x000; 0x002 + 1 + (−8) → 0xFFB).
- Per edge, with rst high:
  - `redirect`: `pc <= target`, `flush <= 1`, `v_id <= 1`, `pc_id <= pc`.
  - Otherwise, when `rom_rd` is 1: `pc <= pc+1`, `v_id <= 1`, `pc_id <= pc`, `flush <= 0`.
  - Otherwise (`rom_rd` is 0): `pc` and `pc_id` hold, `v_id <= 0`, `flush <= 0`.
  - `pc_ex <= pc_id` on every edge.
- `ROM_data = (v_id & ~flush & ~silence) ? rom_q : 16'h0000`. This is combinational from the registered ROM output and the flags.
- The word fetched in the redirect cycle is squashed by `flush`. The earlier wrong-path word has already reached decode and is squashed by control via `silence`.
- A redirect asserted while `flush` is 1 is honoured normally: the target is reloaded and `flush` stays 1 for one more cycle.
- A redirect wins over `rom_rd` being 0: the PC always loads the target.

## Timing
- Reset (async assert, while `rst` is 0):
  - `pc`, `rom_addr`, `pc_id`, `pc_ex` = `BOOT_PC`.
  - `v_id` = 0, `flush` = 0.
  - `ROM_data` = 0, `redirect` = 0 (inputs permitting), `ret_addr` = `BOOT_PC+1`.
- Deassertion is taken synchronously on the next edge. A mid-operation reset kills all in-flight words and returns to `BOOT_PC` immediately, with no glitch on `ROM_data` (it is forced to 0 via `v_id`).
- Fetch latency:
  - Address A is driven in cycle k.
  - `rom_q`/`ROM_data` = mem[A] in cycle k+1.
  - Control decodes it at the end of k+1; EX runs in k+2.
- Redirect timing:
  - The redirect is resolved in EX cycle k+2 and `pc` = target from cycle k+3.
  - `ROM_data` is 0 in cycle k+3.
  - mem[target] appears in cycle k+4.
  - Taken-branch/jump penalty: 2 words (1 squashed here, 1 by control).
- `rom_rd` low in cycle k gives a bubble (`ROM_data` = 0) in k+1, and `rom_addr` is unchanged.
- `ret_addr` is valid during the EX cycle of jal and is captured by the write-back path at the end of that cycle.

## Test plan
- Reset release, `BOOT_PC`=0, `rom_rd`=1, mem[i]=0x1000+i:
  - `rom_addr` steps 0,1,2,…
  - `ROM_data` = 0 in the first cycle, then 0x1000, 0x1001, … one cycle behind.
- Jump: `jump_sel`=1 with `jump_target`=0x040 while `pc_ex`=0x005:
  - Next cycle `rom_addr`=0x040 and `ROM_data`=0.
  - The following cycle `ROM_data`=mem[0x40].
- beq taken, `pc_ex`=0x010, `branch_off`=6'h3C (−4), `alu_eq`=1:
  - Target is 0x00D.
  - With `alu_eq`=0: no redirect, and `rom_addr` continues sequentially.
- Wrap and priority:
  - `pc`=0xFFF, no redirect: `rom_addr`=0x000 next.
  - `jump_sel`=1 and a taken beq in the same cycle: target = `jump_target`.
- Stall, silence and back-to-back:
  - `rom_rd`=0 for 3 cycles: `rom_addr` holds and 3 zero words appear on `ROM_data`.
  - `silence`=1: `ROM_data`=0 regardless of `rom_q`.
  - Two redirects in consecutive cycles: the second target wins.
- Async reset mid-stream: `rst`=0 asserted between edges:
  - `rom_addr`=`BOOT_PC` and `ROM_data`=0 immediately.
  - After release, fetch restarts exactly as in the first scenario.
